usb_fs_tx: RTL and testbench



---
 rtl/usb_tx_pkg.sv | 33 +++
 rtl/usb_bit_strobe.sv | 29 ++
 rtl/usb_fs_tx.sv | 166 ++++++++++++++++
 tb/tb_usb_fs_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared constants and helpers for the full-speed USB transmit path.
// Line symbols are packed as {dp, dn}.
package usb_tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_EOP_SE0 = 3'd3;
  localparam logic [2:0] ST_EOP_J   = 3'd4;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [1:0] OP_NORMAL     = 2'b00;
  localparam logic [1:0] OP_NODRIVE    = 2'b01;
  localparam logic [1:0] OP_RAW        = 2'b10;
  localparam logic [1:0] OP_NORMAL_ALT = 2'b11;

  // Line level (1 = J) for the next bit; raw mode maps the bit straight to J/K.
  function automatic logic nrzi_next(input logic raw, input logic data_bit, input logic prev_j);
    if (raw) return data_bit;
    return data_bit ? prev_j : ~prev_j;
  endfunction

  function automatic logic [1:0] line_sym(input logic j);
    return j ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_bit_strobe.sv
// Bit-time divider: strobe marks the last system clock of each bit period.
// A synchronous clear restarts the period so the next bit lasts a full CLK_DIV clocks.
module usb_bit_strobe #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic strobe
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= TOP;
    end else if (clear || cnt == '0) begin
      cnt <= TOP;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign strobe = (cnt == '0) && !clear;

endmodule

// File: rtl/usb_fs_tx.sv
// Full-speed USB transmit serializer: UTMI bytes in, SYNC + NRZI/bit-stuffed data + EOP out.
// Handshake: utmi_tx_ready pulses for one clk at a byte-load point while utmi_tx_valid is high; the byte is taken at that edge.
module usb_fs_tx
  import usb_tx_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] utmi_tx_data,
  input  logic       utmi_tx_valid,
  output logic       utmi_tx_ready,
  input  logic [1:0] utmi_tx_op_mode,
  output logic       usb_dp_o,
  output logic       usb_dn_o,
  output logic       usb_oe,
  output logic       tx_busy,
  output logic [2:0] fsm_state
);

  logic [2:0] state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_idx, idx_n;
  logic [2:0] ones, ones_n;
  logic       line_j, line_n;
  logic       stuff, stuff_n;
  logic       raw, raw_n;
  logic [1:0] sym_n;
  logic       oe_n;
  logic       strobe;
  logic       in_byte, need_stuff, load_pt, start;
  logic       emit, nb;

  usb_bit_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_IDLE),
    .strobe (strobe)
  );

  assign in_byte    = (state == ST_SYNC) || (state == ST_DATA);
  assign need_stuff = in_byte && !raw && !stuff && (ones == STUFF_LIMIT);
  assign load_pt    = strobe && in_byte && !need_stuff && (bit_idx == 3'd7);
  assign start      = (state == ST_IDLE) && utmi_tx_valid && (utmi_tx_op_mode != OP_NODRIVE);

  assign utmi_tx_ready = load_pt && utmi_tx_valid;
  assign tx_busy       = (state != ST_IDLE);
  assign fsm_state     = state;

  // shreg holds the bits not yet on the line; each pad update is computed one clk ahead and registered.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = bit_idx;
    ones_n  = ones;
    line_n  = line_j;
    stuff_n = stuff;
    raw_n   = raw;
    sym_n   = {usb_dp_o, usb_dn_o};
    oe_n    = usb_oe;
    emit    = 1'b0;
    nb      = 1'b0;
    case (state)
      ST_IDLE: begin
        sym_n = LINE_J;
        oe_n  = 1'b0;
        if (start) begin
          state_n = ST_SYNC;
          shreg_n = {1'b0, SYNC_BYTE[7:1]};
          idx_n   = 3'd0;
          stuff_n = 1'b0;
          raw_n   = (utmi_tx_op_mode == OP_RAW);
          line_n  = nrzi_next(raw_n, SYNC_BYTE[0], 1'b1);
          ones_n  = (SYNC_BYTE[0] && !raw_n) ? 3'd1 : 3'd0;
          sym_n   = line_sym(line_n);
          oe_n    = 1'b1;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (strobe) begin
          if (need_stuff) begin
            stuff_n = 1'b1;
            ones_n  = 3'd0;
            line_n  = ~line_j;
            sym_n   = line_sym(line_n);
          end else begin
            stuff_n = 1'b0;
            if (bit_idx == 3'd7) begin
              if (utmi_tx_valid) begin
                state_n = ST_DATA;
                shreg_n = {1'b0, utmi_tx_data[7:1]};
                idx_n   = 3'd0;
                nb      = utmi_tx_data[0];
                emit    = 1'b1;
              end else begin
                state_n = ST_EOP_SE0;
                idx_n   = 3'd0;
                sym_n   = LINE_SE0;
              end
            end else begin
              shreg_n = {1'b0, shreg[7:1]};
              idx_n   = bit_idx + 3'd1;
              nb      = shreg[0];
              emit    = 1'b1;
            end
          end
        end
      end
      ST_EOP_SE0: begin
        if (strobe) begin
          if (bit_idx == 3'd1) begin
            state_n = ST_EOP_J;
            sym_n   = LINE_J;
          end else begin
            idx_n = bit_idx + 3'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (strobe) begin
          state_n = ST_IDLE;
          line_n  = 1'b1;
          sym_n   = LINE_J;
          oe_n    = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        sym_n   = LINE_J;
        oe_n    = 1'b0;
      end
    endcase
    if (emit) begin
      line_n = nrzi_next(raw, nb, line_j);
      ones_n = (nb && !raw) ? ones + 3'd1 : 3'd0;
      sym_n  = line_sym(line_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= 8'h00;
      bit_idx  <= 3'd0;
      ones     <= 3'd0;
      line_j   <= 1'b1;
      stuff    <= 1'b0;
      raw      <= 1'b0;
      usb_dp_o <= 1'b1;
      usb_dn_o <= 1'b0;
      usb_oe   <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= idx_n;
      ones     <= ones_n;
      line_j   <= line_n;
      stuff    <= stuff_n;
      raw      <= raw_n;
      usb_dp_o <= sym_n[1];
      usb_dn_o <= sym_n[0];
      usb_oe   <= oe_n;
    end
  end

endmodule

// File: tb/tb_usb_fs_tx.sv
// Bench for usb_fs_tx: hand-written line symbol tables and ready timings feed scoreboard
// queues; a negedge monitor pops and compares them whenever a packet is on the wire.
module tb_usb_fs_tx;
  import usb_tx_pkg::*;

  localparam int CLK_DIV = 5;
  localparam logic [1:0] SYM_END = 2'b11;

  logic       clk;
  logic       rst;
  logic [7:0] utmi_tx_data;
  logic       utmi_tx_valid;
  logic       utmi_tx_ready;
  logic [1:0] utmi_tx_op_mode;
  logic       usb_dp_o;
  logic       usb_dn_o;
  logic       usb_oe;
  logic       tx_busy;
  logic [2:0] fsm_state;

  usb_fs_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .utmi_tx_data    (utmi_tx_data),
    .utmi_tx_valid   (utmi_tx_valid),
    .utmi_tx_ready   (utmi_tx_ready),
    .utmi_tx_op_mode (utmi_tx_op_mode),
    .usb_dp_o        (usb_dp_o),
    .usb_dn_o        (usb_dn_o),
    .usb_oe          (usb_oe),
    .tx_busy         (tx_busy),
    .fsm_state       (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  int         rdy_q[$];
  int         gap_q[$];
  bit         mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // J/K/0(SE0)/E(end of packet, oe must be low); spaces are ignored
  task automatic push_line(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "J") exp_q.push_back(LINE_J);
      else if (c == "K") exp_q.push_back(LINE_K);
      else if (c == "0") exp_q.push_back(LINE_SE0);
      else if (c == "E") exp_q.push_back(SYM_END);
    end
  endtask

  // scoreboard monitor
  logic [1:0] cur;
  int         phase, pkt_cyc, gap;
  bit         in_pkt, prev_ready, after_end;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      in_pkt     = 1'b0;
      prev_ready = 1'b0;
      after_end  = 1'b0;
    end else begin
      if (utmi_tx_ready) check("ready_pulse_width", {31'd0, prev_ready}, 32'd0);
      prev_ready = utmi_tx_ready;
      if (!in_pkt && usb_oe) begin
        in_pkt  = 1'b1;
        phase   = 0;
        pkt_cyc = 0;
        if (after_end && gap_q.size() > 0) check("idle_gap", gap, gap_q.pop_front());
        after_end = 1'b0;
      end
      if (in_pkt) begin
        if (phase == 0) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_bit");
            cur = SYM_END;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        if (utmi_tx_ready) begin
          if (rdy_q.size() == 0) fail_now("unexpected_ready");
          else check("ready_time", pkt_cyc, rdy_q.pop_front());
        end
        if (cur == SYM_END) begin
          check("eop_release", {tx_busy, usb_oe, usb_dp_o, usb_dn_o}, 4'b0010);
          in_pkt    = 1'b0;
          after_end = 1'b1;
          gap       = 1;
        end else begin
          check("line", {tx_busy, usb_oe, usb_dp_o, usb_dn_o}, {2'b11, cur});
        end
        phase = (phase == CLK_DIV - 1) ? 0 : phase + 1;
        pkt_cyc++;
      end else if (after_end && !usb_oe) begin
        gap++;
      end
    end
  end

  // driver tasks
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (utmi_tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("ready_timeout");
  endtask

  task automatic send(input logic [1:0] mode, input int n, input logic [7:0] b0, input logic [7:0] b1);
    bit ok;
    utmi_tx_op_mode = mode;
    utmi_tx_data    = b0;
    utmi_tx_valid   = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_ready(ok);
      if (!ok) break;
      @(posedge clk);
      #1;
      if (i + 1 < n) utmi_tx_data = b1;
      else utmi_tx_valid = 1'b0;
    end
    utmi_tx_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    @(negedge clk);
    while ((tx_busy || usb_oe) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail_now("idle_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst             = 1'b1;
    utmi_tx_valid   = 1'b0;
    utmi_tx_data    = 8'h00;
    utmi_tx_op_mode = OP_NORMAL;
    mon_en          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {usb_dp_o, usb_dn_o, usb_oe, utmi_tx_ready, tx_busy}, 5'b10000);
    check("reset_state", fsm_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // one byte 0x00
    push_line("KJKJKJKK JKJKJKJK 00J E");
    rdy_q.push_back(39);
    send(OP_NORMAL, 1, 8'h00, 8'h00);
    wait_idle();

    // 0xFF: stuff after SYNC's trailing one plus five data ones, then 0x00
    push_line("KJKJKJKK KKKKKJJJJ KJKJKJKJ 00J E");
    rdy_q.push_back(39);
    rdy_q.push_back(84);
    send(OP_NORMAL, 2, 8'hFF, 8'h00);
    wait_idle();

    // 0x3F then 0x80
    push_line("KJKJKJKK KKKKKJJKJ KJKJKJKK 00J E");
    rdy_q.push_back(39);
    rdy_q.push_back(84);
    send(OP_NORMAL, 2, 8'h3F, 8'h80);
    wait_idle();

    // raw mode 0xFF 0x00: no stuffing, 1 -> J, 0 -> K
    push_line("KKKKKKKJ JJJJJJJJ KKKKKKKK 00J E");
    rdy_q.push_back(39);
    rdy_q.push_back(79);
    send(OP_RAW, 2, 8'hFF, 8'h00);
    wait_idle();

    // op mode 11 behaves as normal
    push_line("KJKJKJKK JKJKJKJK 00J E");
    rdy_q.push_back(39);
    send(OP_NORMAL_ALT, 1, 8'h00, 8'h00);
    wait_idle();

    // non-driving mode ignores tx_valid in IDLE
    utmi_tx_op_mode = OP_NODRIVE;
    utmi_tx_data    = 8'hA5;
    utmi_tx_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk);
      check("nodrive_idle", {tx_busy, usb_oe, usb_dp_o, usb_dn_o}, 4'b0010);
    end
    utmi_tx_valid   = 1'b0;
    utmi_tx_op_mode = OP_NORMAL;
    @(negedge clk);

    // back-to-back: tx_valid raised during EOP_J of a 2-byte packet
    push_line("KJKJKJKK JKJKJKJK JKJKJKJK 00J E");
    rdy_q.push_back(39);
    rdy_q.push_back(79);
    push_line("KJKJKJKK JKJKJKJK 00J E");
    rdy_q.push_back(39);
    utmi_tx_data  = 8'h00;
    utmi_tx_valid = 1'b1;
    wait_ready(ok);
    @(posedge clk);
    #1;
    gap_q.push_back(1);
    wait_ready(ok);
    @(posedge clk);
    #1;
    utmi_tx_valid = 1'b0;
    repeat (52) @(posedge clk);
    #1;
    utmi_tx_valid = 1'b1;
    wait_ready(ok);
    @(posedge clk);
    #1;
    utmi_tx_valid = 1'b0;
    wait_idle();
    check("gap_consumed", gap_q.size(), 0);

    // reset 17 clk into the data byte
    mon_en        = 1'b0;
    utmi_tx_data  = 8'h00;
    utmi_tx_valid = 1'b1;
    wait_ready(ok);
    @(posedge clk);
    #1;
    utmi_tx_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    check("pre_reset_oe", {tx_busy, usb_oe}, 2'b11);
    rst = 1'b1;
    #1;
    check("midpkt_reset", {usb_oe, usb_dp_o, usb_dn_o, utmi_tx_ready, tx_busy}, 5'b01000);
    check("midpkt_reset_state", fsm_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    rdy_q.delete();
    @(negedge clk);
    mon_en = 1'b1;

    // fresh packet after reset starts with SYNC K
    push_line("KJKJKJKK JKJKJKJK 00J E");
    rdy_q.push_back(39);
    send(OP_NORMAL, 1, 8'h00, 8'h00);
    wait_idle();

    check("drain_line", exp_q.size(), 0);
    check("drain_ready", rdy_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
